instr_fetch_queue: RTL and testbench

- Parametrised next-generation fetch stage for the 5-stage pipeline.
- Holds the PC and an internal word-addressed instruction memory with a preload write port.
- Adds a prefetch FIFO so fetch keeps running while decode back-pressures. This replaces clock gating with a valid/ready handshake.
- Supports redirect (jump/branch) with FIFO flush. Sits between the PC-select logic in EX and the IF/ID boundary.

---
 rtl/instr_fetch_queue.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Fetch stage for the 5-stage pipeline. It holds the fetch PC and a
// word-addressed instruction memory that is loaded through a preload port. A
// small prefetch FIFO sits between the memory and the IF/ID boundary. This
// lets fetch keep running while decode applies back-pressure through the
// out_valid/out_ready handshake.
//
// A redirect (jump/branch) from EX flushes the FIFO and reloads the fetch PC.
// Redirect takes priority over fetching.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   redirect_valid load redirect_pc and flush the queue this cycle
//   redirect_pc    redirect target (bits [1:0] treated as zero)
//   out_ready      decode can accept the head instruction
//   out_valid      queue head is valid
//   out_pc         PC of the head instruction (0 when empty)
//   out_instr      head instruction word (0 when empty)
//   fifo_count     current queue occupancy, 0..FIFO_DEPTH
//   fetch_pc       PC of the next word to be fetched
//   imem_we        preload write enable
//   imem_waddr     preload word index
//   imem_wdata     preload data
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     IMEM_DEPTH = 256,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [XLEN-1:0]               out_pc,
  output logic [XLEN-1:0]               out_instr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [XLEN-1:0]               fetch_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [XLEN-1:0]               imem_wdata
);

  localparam int unsigned      IMEM_AW  = $clog2(IMEM_DEPTH);
  localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Instruction memory: synchronous write, combinational read.
  logic [XLEN-1:0]    imem [IMEM_DEPTH];
  logic [IMEM_AW-1:0] fetch_idx;
  logic [XLEN-1:0]    fetch_word;

  // Queue state.
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  entry_pc_q    [FIFO_DEPTH];
  logic [XLEN-1:0]  entry_instr_q [FIFO_DEPTH];

  logic pop;
  logic push;

  // ---------------------------------------------------------------------------
  // Instruction memory
  // ---------------------------------------------------------------------------
  // The memory is not reset, and preload writes are accepted even while reset
  // is asserted. A word written on the same edge as a fetch of that word is
  // captured with its old contents, because the read is combinational from
  // the pre-edge array.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  // Upper PC bits are ignored, so fetch wraps modulo IMEM_DEPTH words.
  assign fetch_idx  = fetch_pc_q[IMEM_AW+1:2];
  assign fetch_word = imem[fetch_idx];

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A full queue may still accept a new entry when the head leaves on the
  // same edge.
  assign push      = !redirect_valid & ((count_q != CNT_FULL) | pop);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      // A pop on this edge has already been seen by decode. The rest of the
      // queue belongs to the wrong path, so everything is dropped.
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_pc & ~XLEN'(3);
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue storage
  // ---------------------------------------------------------------------------
  // The storage is not reset. Entries are only visible through the head
  // pointer while count is nonzero, and the outputs are forced to zero
  // otherwise.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_pc_q[wr_ptr_q]    <= fetch_pc_q;
      entry_instr_q[wr_ptr_q] <= fetch_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The head is read straight from registered storage. It therefore stays
  // stable until it is popped, flushed or reset.
  assign out_pc     = out_valid ? entry_pc_q[rd_ptr_q]    : '0;
  assign out_instr  = out_valid ? entry_instr_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign fetch_pc   = fetch_pc_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Scoreboard bench for instr_fetch_queue.
//
// The reference model keeps the following state:
//   - a memory image
//   - the expected fetch PC
//   - the expected queue contents, as a SystemVerilog queue of {pc, instr}
//
// At every rising edge the model applies the fetch rules to the inputs that
// were held during the cycle:
//   - reset clears the queue and PC
//   - redirect flushes and reloads
//   - otherwise an entry is pushed when there is room or the head leaves
//
// A separate monitor runs at every falling edge. It compares the DUT head
// with the front of the expected queue, pops it when decode accepts it, and
// checks count, valid and fetch_pc against the model.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [31:0] RESET_PC   = 32'h0;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  fifo_count;
  logic [31:0] fetch_pc;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;

  instr_fetch_queue #(
    .XLEN      (XLEN),
    .IMEM_DEPTH(IMEM_DEPTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .fifo_count    (fifo_count),
    .fetch_pc      (fetch_pc),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Reference model state.
  entry_t      sb[$];
  logic [31:0] mem_model [IMEM_DEPTH];
  logic [31:0] mpc;
  bit          popped;

  int checks;
  int errors;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Apply the fetch rules for one rising edge, using the inputs held during
  // the cycle that just ended.
  task automatic model_step();
    int cnt_before;
    cnt_before = sb.size() + (popped ? 1 : 0);
    if (!reset) begin
      sb.delete();
      mpc = RESET_PC;
    end else if (redirect_valid) begin
      sb.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else if (cnt_before < FIFO_DEPTH || popped) begin
      sb.push_back('{pc: mpc, instr: mem_model[mpc[9:2]]});
      mpc = mpc + 32'd4;
    end
    // The write lands after any fetch on the same edge has read the old word.
    if (imem_we) mem_model[imem_waddr] = imem_wdata;
    popped = 1'b0;
  endtask

  // Wait for an edge, advance the model, then drive inputs for the next edge.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy,
                      input logic we, input logic [7:0] wa,
                      input logic [31:0] wd);
    @(posedge clk);
    model_step();
    #2;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    imem_we        = we;
    imem_waddr     = wa;
    imem_wdata     = wd;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, rdy, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic redir(input logic [31:0] rpc, input logic rdy);
    step(1'b1, rpc, rdy, 1'b0, 8'h0, 32'h0);
  endtask

  // Monitor: compare against the model at each falling edge.
  initial begin : monitor
    entry_t exp_e;
    forever begin
      @(negedge clk);
      check("fifo_count", 64'(fifo_count), 64'(sb.size()));
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      check("fetch_pc", 64'(fetch_pc), 64'(mpc));
      if (sb.size() == 0) begin
        check("idle_pc", 64'(out_pc), 64'h0);
        check("idle_instr", 64'(out_instr), 64'h0);
      end else begin
        exp_e = sb[0];
        check("head_pc", 64'(out_pc), 64'(exp_e.pc));
        check("head_instr", 64'(out_instr), 64'(exp_e.instr));
        if (out_ready) begin
          void'(sb.pop_front());
          popped = 1'b1;
        end
      end
    end
  end

  initial begin : driver
    popped         = 1'b0;
    mpc            = RESET_PC;
    checks         = 0;
    errors         = 0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    imem_we        = 1'b0;
    imem_waddr     = 8'h0;
    imem_wdata     = 32'h0;
    for (int i = 0; i < IMEM_DEPTH; i++) mem_model[i] = 32'hx;

    reset = 1'b1;
    #1 reset = 1'b0;

    // Preload memory while reset is held (writes proceed during reset).
    for (int i = 0; i < IMEM_DEPTH; i++)
      step(1'b0, 32'h0, 1'b1, 1'b1, 8'(i), 32'h1000_0000 + 32'(i));
    idle(1'b1);
    check("rst_fetch_pc", 64'(fetch_pc), 64'(RESET_PC));
    check("rst_count", 64'(fifo_count), 64'h0);
    reset = 1'b1;

    // Streaming with decode always ready: one instruction per cycle.
    idle(1'b1);
    check("first_valid", 64'(out_valid), 64'h1);
    check("first_pc", 64'(out_pc), 64'h0);
    check("first_instr", 64'(out_instr), 64'h1000_0000);
    repeat (9) idle(1'b1);

    // Back-pressure from a fresh start at PC 0.
    redir(32'h0, 1'b0);
    idle(1'b0);
    repeat (4) idle(1'b0);
    check("full_count", 64'(fifo_count), 64'h4);
    check("full_fetch_pc", 64'(fetch_pc), 64'h10);
    repeat (2) idle(1'b0);
    check("hold_fetch_pc", 64'(fetch_pc), 64'h10);
    idle(1'b1);
    // Full queue with push and pop together on every edge.
    repeat (4) idle(1'b1);
    check("steady_count", 64'(fifo_count), 64'h4);
    check("steady_fetch_pc", 64'(fetch_pc), 64'h20);

    // Redirect to 0x40 while count=3 and the head is at 0x8.
    redir(32'h8, 1'b0);
    idle(1'b0);
    repeat (2) idle(1'b0);
    redir(32'h40, 1'b0);
    check("pre_redir_count", 64'(fifo_count), 64'h3);
    check("pre_redir_head", 64'(out_pc), 64'h8);
    idle(1'b1);
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_count", 64'(fifo_count), 64'h0);
    idle(1'b1);
    check("target_pc", 64'(out_pc), 64'h40);
    check("target_instr", 64'(out_instr), 64'h1000_0010);

    // Redirect targets are word aligned.
    redir(32'h47, 1'b0);
    idle(1'b0);
    check("align_fetch_pc", 64'(fetch_pc), 64'h44);
    idle(1'b0);
    check("align_instr", 64'(out_instr), 64'h1000_0011);

    // The top of the address space wraps to PC 0.
    redir(32'hFFFF_FFFC, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("wrap_pc", 64'(out_pc), 64'hFFFF_FFFC);
    check("wrap_instr", 64'(out_instr), 64'h1000_00FF);
    check("wrap_fetch_pc", 64'(fetch_pc), 64'h0);
    idle(1'b0);

    // A write colliding with a fetch of the same word returns the old data.
    redir(32'h8, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 8'd2, 32'hDEAD_BEEF);
    idle(1'b1);
    check("collide_pc", 64'(out_pc), 64'h8);
    check("collide_old", 64'(out_instr), 64'h1000_0002);
    redir(32'h8, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("refetch_new", 64'(out_instr), 64'hDEAD_BEEF);

    // Asynchronous reset mid-stream with count=2.
    redir(32'h0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    check("pre_rst_count", 64'(fifo_count), 64'h2);
    #1 reset = 1'b0;
    sb.delete();
    mpc = RESET_PC;
    #1;
    check("async_valid", 64'(out_valid), 64'h0);
    check("async_fetch_pc", 64'(fetch_pc), 64'(RESET_PC));
    check("async_count", 64'(fifo_count), 64'h0);
    idle(1'b0);
    reset = 1'b1;
    idle(1'b0);
    check("post_rst_pc", 64'(out_pc), 64'h0);
    check("retained_mem", 64'(out_instr), 64'h1000_0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(7) == 0),
           (($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(1023))),
           1'($urandom), ($urandom_range(3) == 0),
           8'($urandom), $urandom);
    end
    idle(1'b1);
    idle(1'b1);

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
